// File: rtl/sorted_stream_checker_pkg.sv
// Shared types, defaults and the key-order predicate for the sorted stream checker.
// Build option: define STRICT_ORDER_EN to require strictly ascending keys (equal keys
// become violations); by default duplicates are legal (non-decreasing order).
package sorted_stream_checker_pkg;

    localparam int unsigned DEF_E_LOG = 5;
    localparam int unsigned DEF_DATW  = 64;
    localparam int unsigned DEF_KEYW  = 32;
    localparam int unsigned DEF_CNTW  = 32;

    // Widest key the order predicate accepts; narrower keys are zero-extended.
    localparam int unsigned MAX_KEYW  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } chk_state_e;

    // True when cur may legally follow prev in a sorted run.
    function automatic logic key_in_order(input logic [MAX_KEYW-1:0] prev,
                                          input logic [MAX_KEYW-1:0] cur);
`ifdef STRICT_ORDER_EN
        return prev < cur;
`else
        return prev <= cur;
`endif
    endfunction

endpackage

// File: rtl/sorted_stream_checker_order_vec_cmp.sv
// Combinational E-lane order check of one beat against the previous beat's last key.
// Produces the per-lane violation vector and the lowest violating lane.
module order_vec_cmp
    import sorted_stream_checker_pkg::*;
#(
    parameter int unsigned E_LOG = DEF_E_LOG,
    parameter int unsigned DATW  = DEF_DATW,
    parameter int unsigned KEYW  = DEF_KEYW
) (
    input  logic [(DATW<<E_LOG)-1:0] din,
    input  logic [KEYW-1:0]          prev_key,
    input  logic                     check_prev,
    output logic [(1<<E_LOG)-1:0]    viol_vec_c,
    output logic                     viol_c,
    output logic [E_LOG-1:0]         first_lane_c
);

    localparam int unsigned E = 1 << E_LOG;

    // Record payload above the key is carried but never inspected here.
    logic unused_payload_c;
    assign unused_payload_c = ^din;

    // Lane 0 compares against the previous beat; lane j against lane j-1.
    always_comb begin
        viol_vec_c    = '0;
        viol_vec_c[0] = check_prev &&
                        !key_in_order(MAX_KEYW'(prev_key), MAX_KEYW'(din[0 +: KEYW]));
        for (int j = 1; j < int'(E); j++) begin
            viol_vec_c[j] = !key_in_order(MAX_KEYW'(din[DATW*(j-1) +: KEYW]),
                                          MAX_KEYW'(din[DATW*j +: KEYW]));
        end
    end

    // Lowest failing lane wins.
    always_comb begin
        first_lane_c = '0;
        for (int j = int'(E) - 1; j >= 0; j--) begin
            if (viol_vec_c[j]) begin
                first_lane_c = E_LOG'(j);
            end
        end
    end

    assign viol_c = |viol_vec_c;

endmodule

// File: rtl/sorted_stream_checker.sv
// Passive receive-side monitor for the merge network output stream: checks ascending
// key order within and across beats per run, counts beats/runs, latches first violation.
// Build option: STRICT_ORDER_EN selects strict (<) ordering instead of non-decreasing.
module sorted_stream_checker
    import sorted_stream_checker_pkg::*;
#(
    parameter int unsigned E_LOG = DEF_E_LOG,
    parameter int unsigned DATW  = DEF_DATW,
    parameter int unsigned KEYW  = DEF_KEYW,
    parameter int unsigned CNTW  = DEF_CNTW
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic [CNTW-1:0]          RUN_LEN,
    input  logic [(DATW<<E_LOG)-1:0] DIN,
    input  logic                     DINEN,
    output logic                     ERR,
    output logic [CNTW-1:0]          ERR_BEAT,
    output logic [E_LOG-1:0]         ERR_LANE,
    output logic [CNTW-1:0]          BEAT_CNT,
    output logic [CNTW-1:0]          RUN_CNT,
    output logic                     RUN_DONE,
    output logic [KEYW-1:0]          LAST_KEY
);

    localparam int unsigned E = 1 << E_LOG;

    chk_state_e        state_q, state_d;
    logic              first_q, first_d;
    logic [CNTW-1:0]   rec_q, rec_d;
    logic [CNTW-1:0]   run_len_q, run_len_d;
    logic              err_q, err_d;
    logic [CNTW-1:0]   err_beat_q, err_beat_d;
    logic [E_LOG-1:0]  err_lane_q, err_lane_d;
    logic [CNTW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNTW-1:0]   run_cnt_q, run_cnt_d;
    logic              run_done_q, run_done_d;
    logic [KEYW-1:0]   last_key_q, last_key_d;

    logic [E-1:0]      ord_vec_c;
    logic              ord_viol_c;
    logic [E_LOG-1:0]  ord_lane_c;
    logic [CNTW-1:0]   run_len_c;
    logic [CNTW:0]     rec_sum_c;
    logic              run_end_c;
    logic              bnd_err_c;
    logic              beat_viol_c;
    logic [E_LOG-1:0]  beat_lane_c;

    order_vec_cmp #(
        .E_LOG (E_LOG),
        .DATW  (DATW),
        .KEYW  (KEYW)
    ) u_cmp (
        .din          (DIN),
        .prev_key     (last_key_q),
        .check_prev   (!first_q),
        .viol_vec_c   (ord_vec_c),
        .viol_c       (ord_viol_c),
        .first_lane_c (ord_lane_c)
    );

    // Run boundary detection; RUN_LEN is live only while idle, latched afterwards.
    always_comb begin
        run_len_c   = (state_q == ST_IDLE) ? RUN_LEN : run_len_q;
        rec_sum_c   = {1'b0, rec_q} + (CNTW+1)'(E);
        run_end_c   = (run_len_c != '0) && (rec_sum_c >= {1'b0, run_len_c});
        bnd_err_c   = run_end_c && (rec_sum_c != {1'b0, run_len_c});
        beat_viol_c = ord_viol_c || bnd_err_c;
        beat_lane_c = ord_viol_c ? ord_lane_c : E_LOG'(E - 1);
    end

    // Next-state, counters and error capture for one accepted beat.
    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        rec_d      = rec_q;
        run_len_d  = run_len_q;
        err_d      = err_q;
        err_beat_d = err_beat_q;
        err_lane_d = err_lane_q;
        beat_cnt_d = beat_cnt_q;
        run_cnt_d  = run_cnt_q;
        run_done_d = 1'b0;
        last_key_d = last_key_q;

        if (state_q == ST_IDLE) begin
            run_len_d = RUN_LEN;
        end

        if (DINEN) begin
            beat_cnt_d = beat_cnt_q + CNTW'(1);
            last_key_d = DIN[DATW*(E-1) +: KEYW];

            if (run_end_c) begin
                rec_d      = '0;
                first_d    = 1'b1;
                run_done_d = 1'b1;
                run_cnt_d  = run_cnt_q + CNTW'(1);
            end else begin
                rec_d      = rec_sum_c[CNTW-1:0];
                first_d    = 1'b0;
            end

            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (beat_viol_c) begin
                        state_d    = ST_HALT;
                        err_d      = 1'b1;
                        err_beat_d = beat_cnt_q;
                        err_lane_d = beat_lane_c;
                    end else begin
                        state_d    = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    // State register; RST and CLR both return everything to the idle, first-beat state.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b1;
            rec_q      <= '0;
            run_len_q  <= '0;
            err_q      <= 1'b0;
            err_beat_q <= '0;
            err_lane_q <= '0;
            beat_cnt_q <= '0;
            run_cnt_q  <= '0;
            run_done_q <= 1'b0;
            last_key_q <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            rec_q      <= rec_d;
            run_len_q  <= run_len_d;
            err_q      <= err_d;
            err_beat_q <= err_beat_d;
            err_lane_q <= err_lane_d;
            beat_cnt_q <= beat_cnt_d;
            run_cnt_q  <= run_cnt_d;
            run_done_q <= run_done_d;
            last_key_q <= last_key_d;
        end
    end

    assign ERR      = err_q;
    assign ERR_BEAT = err_beat_q;
    assign ERR_LANE = err_lane_q;
    assign BEAT_CNT = beat_cnt_q;
    assign RUN_CNT  = run_cnt_q;
    assign RUN_DONE = run_done_q;
    assign LAST_KEY = last_key_q;

endmodule
